// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the instruction/data memory arbiter.
// Both pipeline ports and the bus use these definitions.
package mem_arb_pkg;

  localparam int XLEN = 32;
  localparam int BE_W = XLEN / 8;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_IF_REQ   = 3'd1,
    S_IF_WAIT  = 3'd2,
    S_MEM_REQ  = 3'd3,
    S_MEM_WAIT = 3'd4
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-outstanding arbiter between fetch and load/store ports.
// The data port wins ties; fetch responses can be dropped by flush.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int XLEN = mem_arb_pkg::XLEN,
  parameter int BE_W = mem_arb_pkg::BE_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic [XLEN-1:0] if_rdata,
  output logic            if_valid,
  input  logic            mem_req,
  input  logic            mem_we,
  input  logic [XLEN-1:0] mem_addr,
  input  logic [XLEN-1:0] mem_wdata,
  input  logic [BE_W-1:0] mem_be,
  output logic [XLEN-1:0] mem_rdata,
  output logic            mem_valid,
  input  logic            flush,
  output logic            stall_if,
  output logic            stall_mem,
  output logic            bus_req,
  output logic            bus_we,
  output logic [XLEN-1:0] bus_addr,
  output logic [XLEN-1:0] bus_wdata,
  output logic [BE_W-1:0] bus_be,
  input  logic            bus_gnt,
  input  logic            bus_rvalid,
  input  logic [XLEN-1:0] bus_rdata
);

  arb_state_t      r_state;
  arb_state_t      w_next;
  logic            r_drop;
  logic            w_drop_nxt;
  logic            r_we;
  logic [XLEN-1:0] r_addr;
  logic [XLEN-1:0] r_wdata;
  logic [BE_W-1:0] r_be;
  logic            w_lat_mem;
  logic            w_lat_if;
  logic            w_bus_req;
  logic            w_if_valid;
  logic            w_mem_valid;

  // State and drop-flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_drop  <= w_drop_nxt;
    end
  end

  // Capture the request fields that the bus sees while requesting
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
    end else if (w_lat_mem) begin
      r_we    <= mem_we;
      r_addr  <= mem_addr;
      r_wdata <= mem_wdata;
      r_be    <= mem_be;
    end else if (w_lat_if) begin
      r_we    <= 1'b0;
      r_addr  <= if_addr;
      r_wdata <= '0;
      r_be    <= '1;
    end
  end

  // Next state, bus request and response pulses
  always_comb begin
    w_next      = r_state;
    w_drop_nxt  = r_drop;
    w_lat_mem   = 1'b0;
    w_lat_if    = 1'b0;
    w_bus_req   = 1'b0;
    w_if_valid  = 1'b0;
    w_mem_valid = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (mem_req) begin
          w_lat_mem = 1'b1;
          w_next    = S_MEM_REQ;
        end else if (if_req && !flush) begin
          w_lat_if = 1'b1;
          w_next   = S_IF_REQ;
        end
      end
      S_IF_REQ: begin
        w_bus_req = 1'b1;
        if (bus_gnt) begin
          w_next     = S_IF_WAIT;
          w_drop_nxt = flush;
        end else if (flush) begin
          w_next = S_IDLE;
        end
      end
      S_IF_WAIT: begin
        if (bus_rvalid) begin
          w_if_valid = !r_drop && !flush;
          w_drop_nxt = 1'b0;
          w_next     = S_IDLE;
        end else if (flush) begin
          w_drop_nxt = 1'b1;
        end
      end
      S_MEM_REQ: begin
        w_bus_req = 1'b1;
        if (bus_gnt) begin
          w_next = S_MEM_WAIT;
        end
      end
      S_MEM_WAIT: begin
        if (bus_rvalid) begin
          w_mem_valid = 1'b1;
          w_next      = S_IDLE;
        end
      end
      default: begin
        w_next     = S_IDLE;
        w_drop_nxt = 1'b0;
      end
    endcase
  end

  assign bus_req   = w_bus_req;
  assign bus_we    = r_we;
  assign bus_addr  = r_addr;
  assign bus_wdata = r_wdata;
  assign bus_be    = r_be;

  assign if_valid  = w_if_valid;
  assign mem_valid = w_mem_valid;
  assign if_rdata  = bus_rdata;
  assign mem_rdata = bus_rdata;

  assign stall_if  = if_req & ~w_if_valid;
  assign stall_mem = mem_req & ~w_mem_valid;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed cycle tables for the memory arbiter.
// Each row drives one cycle and lists the expected outputs.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  typedef struct {
    logic        rst;
    logic        ifr;
    logic [31:0] ifa;
    logic        mr;
    logic        mwe;
    logic [31:0] ma;
    logic [31:0] mwd;
    logic [3:0]  mbe;
    logic        fl;
    logic        g;
    logic        rv;
    logic [31:0] rd;
    logic        e_ifv;
    logic        e_mv;
    logic        e_sif;
    logic        e_sm;
    logic        e_br;
    logic        e_bwe;
    logic [31:0] e_ba;
    logic [31:0] e_bwd;
    logic [3:0]  e_bbe;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_valid;
  logic        flush;
  logic        stall_if;
  logic        stall_mem;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  int checks = 0;
  int failures = 0;
  int row = 0;
  vec_t cur;
  vec_t tbl[$];

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_rdata   (if_rdata),
    .if_valid   (if_valid),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_rdata  (mem_rdata),
    .mem_valid  (mem_valid),
    .flush      (flush),
    .stall_if   (stall_if),
    .stall_mem  (stall_mem),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_be     (bus_be),
    .bus_gnt    (bus_gnt),
    .bus_rvalid (bus_rvalid),
    .bus_rdata  (bus_rdata)
  );

  task automatic in_(input bit r, input bit ifr,
                     input logic [31:0] ifa,
                     input bit mr, input bit mwe,
                     input logic [31:0] ma,
                     input logic [31:0] mwd,
                     input logic [3:0] mbe,
                     input bit fl, input bit g,
                     input bit rv,
                     input logic [31:0] rd);
    cur.rst = r;
    cur.ifr = ifr;
    cur.ifa = ifa;
    cur.mr  = mr;
    cur.mwe = mwe;
    cur.ma  = ma;
    cur.mwd = mwd;
    cur.mbe = mbe;
    cur.fl  = fl;
    cur.g   = g;
    cur.rv  = rv;
    cur.rd  = rd;
  endtask

  task automatic ex(input bit ifv, input bit mv,
                    input bit sif, input bit sm,
                    input bit br, input bit bwe,
                    input logic [31:0] ba,
                    input logic [31:0] bwd,
                    input logic [3:0] bbe);
    cur.e_ifv = ifv;
    cur.e_mv  = mv;
    cur.e_sif = sif;
    cur.e_sm  = sm;
    cur.e_br  = br;
    cur.e_bwe = bwe;
    cur.e_ba  = ba;
    cur.e_bwd = bwd;
    cur.e_bbe = bbe;
    tbl.push_back(cur);
  endtask

  task automatic idle_row();
    in_(0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    ex(0, 0, 0, 0, 0, 0, 0, 0, 4'h0);
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s row=%0d got=%h want=%h",
               nm, row, act, exp);
    end
  endtask

  task automatic step(input vec_t v);
    @(posedge clk);
    #1;
    rst        = v.rst;
    if_req     = v.ifr;
    if_addr    = v.ifa;
    mem_req    = v.mr;
    mem_we     = v.mwe;
    mem_addr   = v.ma;
    mem_wdata  = v.mwd;
    mem_be     = v.mbe;
    flush      = v.fl;
    bus_gnt    = v.g;
    bus_rvalid = v.rv;
    bus_rdata  = v.rd;
    @(negedge clk);
    chk("if_valid", {31'd0, if_valid}, {31'd0, v.e_ifv});
    chk("mem_valid", {31'd0, mem_valid}, {31'd0, v.e_mv});
    chk("stall_if", {31'd0, stall_if}, {31'd0, v.e_sif});
    chk("stall_mem", {31'd0, stall_mem}, {31'd0, v.e_sm});
    chk("bus_req", {31'd0, bus_req}, {31'd0, v.e_br});
    if (v.e_br) begin
      chk("bus_we", {31'd0, bus_we}, {31'd0, v.e_bwe});
      chk("bus_addr", bus_addr, v.e_ba);
      chk("bus_wdata", bus_wdata, v.e_bwd);
      chk("bus_be", {28'd0, bus_be}, {28'd0, v.e_bbe});
    end
    if (v.e_ifv) chk("if_rdata", if_rdata, v.rd);
    if (v.e_mv && !v.mwe) chk("mem_rdata", mem_rdata, v.rd);
    row++;
  endtask

  task automatic run_table();
    foreach (tbl[i]) step(tbl[i]);
    tbl.delete();
  endtask

  initial begin
    rst = 1'b1;
    if_req = 0; if_addr = 0;
    mem_req = 0; mem_we = 0; mem_addr = 0;
    mem_wdata = 0; mem_be = 0; flush = 0;
    bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0;

    // reset state
    in_(1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    ex(0, 0, 0, 0, 0, 0, 0, 0, 4'h0);
    idle_row();
    // fetch only, minimum latency
    in_(0, 1, 'h100, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    ex(0, 0, 1, 0, 0, 0, 0, 0, 4'h0);
    in_(0, 1, 'h100, 0, 0, 0, 0, 4'h0, 0, 1, 0, 0);
    ex(0, 0, 1, 0, 1, 0, 'h100, 0, 4'hF);
    in_(0, 1, 'h100, 0, 0, 0, 0, 4'h0, 0, 0, 1, 'h00500093);
    ex(1, 0, 0, 0, 0, 0, 0, 0, 4'h0);
    idle_row();
    // simultaneous requests: data first
    in_(0, 1, 'h104, 1, 0, 'h2000, 0, 4'hF, 0, 0, 0, 0);
    ex(0, 0, 1, 1, 0, 0, 0, 0, 4'h0);
    in_(0, 1, 'h104, 1, 0, 'h2000, 0, 4'hF, 0, 1, 0, 0);
    ex(0, 0, 1, 1, 1, 0, 'h2000, 0, 4'hF);
    in_(0, 1, 'h104, 1, 0, 'h2000, 0, 4'hF, 0, 0, 1, 'h11223344);
    ex(0, 1, 1, 0, 0, 0, 0, 0, 4'h0);
    in_(0, 1, 'h104, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    ex(0, 0, 1, 0, 0, 0, 0, 0, 4'h0);
    in_(0, 1, 'h104, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    ex(0, 0, 1, 0, 1, 0, 'h104, 0, 4'hF);
    in_(0, 1, 'h104, 0, 0, 0, 0, 4'h0, 0, 1, 0, 0);
    ex(0, 0, 1, 0, 1, 0, 'h104, 0, 4'hF);
    in_(0, 1, 'h104, 0, 0, 0, 0, 4'h0, 0, 0, 1, 'hAAAA5555);
    ex(1, 0, 0, 0, 0, 0, 0, 0, 4'h0);
    idle_row();
    // store, grant delayed, stray rvalid in MEM_REQ
    in_(0, 0, 0, 1, 1, 'h2004, 'hDEADBEEF, 4'h3, 0, 0, 0, 0);
    ex(0, 0, 0, 1, 0, 0, 0, 0, 4'h0);
    in_(0, 0, 0, 1, 1, 'h2004, 'hDEADBEEF, 4'h3, 0, 0, 0, 0);
    ex(0, 0, 0, 1, 1, 1, 'h2004, 'hDEADBEEF, 4'h3);
    in_(0, 0, 0, 1, 1, 'h2004, 'hDEADBEEF, 4'h3, 0, 0, 1, 'h5A5A);
    ex(0, 0, 0, 1, 1, 1, 'h2004, 'hDEADBEEF, 4'h3);
    in_(0, 0, 0, 1, 1, 'h2004, 'hDEADBEEF, 4'h3, 0, 0, 0, 0);
    ex(0, 0, 0, 1, 1, 1, 'h2004, 'hDEADBEEF, 4'h3);
    in_(0, 0, 0, 1, 1, 'h2004, 'hDEADBEEF, 4'h3, 0, 1, 0, 0);
    ex(0, 0, 0, 1, 1, 1, 'h2004, 'hDEADBEEF, 4'h3);
    in_(0, 0, 0, 1, 1, 'h2004, 'hDEADBEEF, 4'h3, 0, 0, 0, 0);
    ex(0, 0, 0, 1, 0, 0, 0, 0, 4'h0);
    in_(0, 0, 0, 1, 1, 'h2004, 'hDEADBEEF, 4'h3, 0, 0, 1, 0);
    ex(0, 1, 0, 0, 0, 0, 0, 0, 4'h0);
    idle_row();
    // flush in IF_WAIT drops the response
    in_(0, 1, 'h200, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    ex(0, 0, 1, 0, 0, 0, 0, 0, 4'h0);
    in_(0, 1, 'h200, 0, 0, 0, 0, 4'h0, 0, 1, 0, 0);
    ex(0, 0, 1, 0, 1, 0, 'h200, 0, 4'hF);
    in_(0, 0, 0, 0, 0, 0, 0, 4'h0, 1, 0, 0, 0);
    ex(0, 0, 0, 0, 0, 0, 0, 0, 4'h0);
    in_(0, 1, 'h300, 0, 0, 0, 0, 4'h0, 0, 0, 1, 'hBAD);
    ex(0, 0, 1, 0, 0, 0, 0, 0, 4'h0);
    in_(0, 1, 'h300, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    ex(0, 0, 1, 0, 0, 0, 0, 0, 4'h0);
    in_(0, 1, 'h300, 0, 0, 0, 0, 4'h0, 0, 1, 0, 0);
    ex(0, 0, 1, 0, 1, 0, 'h300, 0, 4'hF);
    in_(0, 1, 'h300, 0, 0, 0, 0, 4'h0, 0, 0, 1, 'h13);
    ex(1, 0, 0, 0, 0, 0, 0, 0, 4'h0);
    idle_row();
    // flush in IF_REQ before grant: back to IDLE
    in_(0, 1, 'h400, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    ex(0, 0, 1, 0, 0, 0, 0, 0, 4'h0);
    in_(0, 0, 0, 0, 0, 0, 0, 4'h0, 1, 0, 0, 0);
    ex(0, 0, 0, 0, 1, 0, 'h400, 0, 4'hF);
    idle_row();
    idle_row();
    // flush together with grant, then recovery
    in_(0, 1, 'h500, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    ex(0, 0, 1, 0, 0, 0, 0, 0, 4'h0);
    in_(0, 0, 0, 0, 0, 0, 0, 4'h0, 1, 1, 0, 0);
    ex(0, 0, 0, 0, 1, 0, 'h500, 0, 4'hF);
    idle_row();
    in_(0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 1, 'h77);
    ex(0, 0, 0, 0, 0, 0, 0, 0, 4'h0);
    in_(0, 1, 'h600, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    ex(0, 0, 1, 0, 0, 0, 0, 0, 4'h0);
    in_(0, 1, 'h600, 0, 0, 0, 0, 4'h0, 0, 1, 0, 0);
    ex(0, 0, 1, 0, 1, 0, 'h600, 0, 4'hF);
    in_(0, 1, 'h600, 0, 0, 0, 0, 4'h0, 0, 0, 1, 'h66);
    ex(1, 0, 0, 0, 0, 0, 0, 0, 4'h0);
    idle_row();
    // flush has no effect on a load
    in_(0, 0, 0, 1, 0, 'h3000, 0, 4'hF, 1, 0, 0, 0);
    ex(0, 0, 0, 1, 0, 0, 0, 0, 4'h0);
    in_(0, 0, 0, 1, 0, 'h3000, 0, 4'hF, 1, 1, 0, 0);
    ex(0, 0, 0, 1, 1, 0, 'h3000, 0, 4'hF);
    in_(0, 0, 0, 1, 0, 'h3000, 0, 4'hF, 1, 0, 1, 'h99);
    ex(0, 1, 0, 0, 0, 0, 0, 0, 4'h0);
    idle_row();
    run_table();

    // flush coincident with rvalid in IF_WAIT
    in_(0, 1, 'h700, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    ex(0, 0, 1, 0, 0, 0, 0, 0, 4'h0);
    in_(0, 1, 'h700, 0, 0, 0, 0, 4'h0, 0, 1, 0, 0);
    ex(0, 0, 1, 0, 1, 0, 'h700, 0, 4'hF);
    in_(0, 1, 'h704, 0, 0, 0, 0, 4'h0, 1, 0, 1, 'hEE);
    ex(0, 0, 1, 0, 0, 0, 0, 0, 4'h0);
    in_(0, 1, 'h704, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    ex(0, 0, 1, 0, 0, 0, 0, 0, 4'h0);
    in_(0, 1, 'h704, 0, 0, 0, 0, 4'h0, 0, 1, 0, 0);
    ex(0, 0, 1, 0, 1, 0, 'h704, 0, 4'hF);
    in_(0, 1, 'h704, 0, 0, 0, 0, 4'h0, 0, 0, 1, 'h55);
    ex(1, 0, 0, 0, 0, 0, 0, 0, 4'h0);
    idle_row();
    run_table();

    // async reset while requesting drops bus_req at once
    in_(0, 1, 'h800, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    ex(0, 0, 1, 0, 0, 0, 0, 0, 4'h0);
    in_(1, 1, 'h800, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    ex(0, 0, 1, 0, 0, 0, 0, 0, 4'h0);
    in_(0, 1, 'h800, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    ex(0, 0, 1, 0, 0, 0, 0, 0, 4'h0);
    in_(0, 1, 'h800, 0, 0, 0, 0, 4'h0, 0, 1, 0, 0);
    ex(0, 0, 1, 0, 1, 0, 'h800, 0, 4'hF);
    in_(0, 1, 'h800, 0, 0, 0, 0, 4'h0, 0, 0, 1, 'h42);
    ex(1, 0, 0, 0, 0, 0, 0, 0, 4'h0);
    idle_row();
    run_table();

    // reset in MEM_WAIT, late rvalid ignored, then clean fetch
    in_(0, 0, 0, 1, 0, 'h2100, 0, 4'hF, 0, 0, 0, 0);
    ex(0, 0, 0, 1, 0, 0, 0, 0, 4'h0);
    in_(0, 0, 0, 1, 0, 'h2100, 0, 4'hF, 0, 1, 0, 0);
    ex(0, 0, 0, 1, 1, 0, 'h2100, 0, 4'hF);
    in_(1, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    ex(0, 0, 0, 0, 0, 0, 0, 0, 4'h0);
    idle_row();
    idle_row();
    in_(0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 1, 'hCC);
    ex(0, 0, 0, 0, 0, 0, 0, 0, 4'h0);
    idle_row();
    in_(0, 1, 'h900, 0, 0, 0, 0, 4'h0, 0, 0, 0, 0);
    ex(0, 0, 1, 0, 0, 0, 0, 0, 4'h0);
    in_(0, 1, 'h900, 0, 0, 0, 0, 4'h0, 0, 1, 0, 0);
    ex(0, 0, 1, 0, 1, 0, 'h900, 0, 4'hF);
    in_(0, 1, 'h900, 0, 0, 0, 0, 4'h0, 0, 0, 1, 'h1234);
    ex(1, 0, 0, 0, 0, 0, 0, 0, 4'h0);
    idle_row();
    run_table();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
